// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF  = 12;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_NEXT,
    OP_REL,
    OP_ABS,
    OP_CALL,
    OP_RET
  } op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: LIFO of DEPTH program-counter values with occupancy count.
// Entry storage is not reset; only the occupancy is.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned OW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [D-1:0]  push_data,
  output logic [D-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [OW-1:0] occupancy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]  r_mem [DEPTH];
  logic [OW-1:0] r_occ;
  logic [OW-1:0] w_occ_m1;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_occ == OW'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occupancy = r_occ;
  assign w_occ_m1  = r_occ - 1'b1;
  assign w_wr_idx  = r_occ[AW-1:0];
  assign w_rd_idx  = w_occ_m1[AW-1:0];
  assign top       = r_mem[w_rd_idx];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty && !push;

  // Entry storage: write the slot just above the current top on push.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= push_data;
  end

  // Occupancy counter, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (w_do_push) begin
      r_occ <= r_occ + 1'b1;
    end else if (w_do_pop) begin
      r_occ <= w_occ_m1;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, relative/absolute jump, call and return
// with a return-address stack and a sticky stack-error flag.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         absjump_en,
  input  logic         reljump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  input  logic [D-1:0] offset,
  output logic [D-1:0] prog_ctr,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         stack_err
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  op_e           w_op;
  logic [D-1:0]  r_pc;
  logic          r_err;
  logic [D-1:0]  w_pc_inc;
  logic [D-1:0]  w_pc_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_err_set;
  logic [D-1:0]  w_top;
  logic          w_full;
  logic          w_empty;
  logic [OW-1:0] w_occ;

  pc_ret_stack #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty),
    .occupancy (w_occ)
  );

  assign w_pc_inc    = r_pc + 1'b1;
  assign prog_ctr    = r_pc;
  assign stack_err   = r_err;
  assign stack_full  = (w_occ == OW'(DEPTH));
  assign stack_empty = (w_occ == '0);

  // Priority decode of the enables into a single operation.
  always_comb begin
    w_op = OP_NEXT;
    if (ret_en)          w_op = OP_RET;
    else if (call_en)    w_op = OP_CALL;
    else if (absjump_en) w_op = OP_ABS;
    else if (reljump_en) w_op = OP_REL;
  end

  // Next PC and stack control; a failed call/return falls back to increment.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (!stall) begin
      unique case (w_op)
        OP_NEXT: w_pc_nxt = w_pc_inc;
        OP_REL:  w_pc_nxt = r_pc + offset;
        OP_ABS:  w_pc_nxt = target;
        OP_CALL: begin
          if (w_full) begin
            w_pc_nxt  = w_pc_inc;
            w_err_set = 1'b1;
          end else begin
            w_pc_nxt = target;
            w_push   = 1'b1;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_pc_nxt  = w_pc_inc;
            w_err_set = 1'b1;
          end else begin
            w_pc_nxt = w_top;
            w_pop    = 1'b1;
          end
        end
        default: w_pc_nxt = w_pc_inc;
      endcase
    end
  end

  // PC register and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq (D=12, DEPTH=4).
module tb_pc_seq;

  localparam int D     = 12;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         absjump_en = 1'b0;
  logic         reljump_en = 1'b0;
  logic         call_en = 1'b0;
  logic         ret_en = 1'b0;
  logic [D-1:0] target = '0;
  logic [D-1:0] offset = '0;
  logic [D-1:0] prog_ctr;
  logic         stack_full;
  logic         stack_empty;
  logic         stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_seq #(.D(D), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .absjump_en  (absjump_en),
    .reljump_en  (reljump_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .target      (target),
    .offset      (offset),
    .prog_ctr    (prog_ctr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  typedef struct {
    logic         st, rt, cl, ab, rl;
    logic [D-1:0] tgt, off;
    logic [D-1:0] pc;
    logic         full, empty, err;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[12];

  function automatic vec_t mk(bit st, bit rt, bit cl, bit ab, bit rl, int tgt, int off,
                              int pc, bit full, bit empty, bit err);
    vec_t v;
    v.st = st; v.rt = rt; v.cl = cl; v.ab = ab; v.rl = rl;
    v.tgt = tgt[D-1:0]; v.off = off[D-1:0]; v.pc = pc[D-1:0];
    v.full = full; v.empty = empty; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; ret_en = 0; call_en = 0; absjump_en = 0; reljump_en = 0;
    target = '0; offset = '0;
  endtask

  // Called at posedge+1; checks async clear before any edge, releases after one edge.
  task automatic do_reset(input string nm);
    clear_inputs();
    reset = 1'b0;
    #2;
    chk({nm, ".pc"},    int'(prog_ctr),    0);
    chk({nm, ".full"},  int'(stack_full),  0);
    chk({nm, ".empty"}, int'(stack_empty), 1);
    chk({nm, ".err"},   int'(stack_err),   0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string nm, input vec_t v);
    vec_t e;
    stall = v.st; ret_en = v.rt; call_en = v.cl; absjump_en = v.ab; reljump_en = v.rl;
    target = v.tgt; offset = v.off;
    exp_q.push_back(v);
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin
      chk({nm, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".pc"},    int'(prog_ctr),    int'(e.pc));
      chk({nm, ".full"},  int'(stack_full),  int'(e.full));
      chk({nm, ".empty"}, int'(stack_empty), int'(e.empty));
      chk({nm, ".err"},   int'(stack_err),   int'(e.err));
    end
  endtask

  function automatic vec_t idle(int pc, bit full, bit empty, bit err);
    return mk(0, 0, 0, 0, 0, 0, 0, pc, full, empty, err);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //            st rt cl ab rl  tgt    off     pc     fu em er
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,     0,      'h001, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 'h200, 0,      'h200, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0,     5,      'h205, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0,     'hFFB,  'h200, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 'h300, 1,      'h300, 0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 1, 'h050, 1,      'h050, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0,     0,      'h050, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,     0,      'h051, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 'h777, 0,      'h301, 0, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0,     0,      'h301, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 1, 0, 'hFFF, 0,      'hFFF, 0, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,     0,      'h000, 0, 1, 0);

    // Reset then 10 idle cycles.
    do_reset("rst0");
    for (int i = 1; i <= 10; i++) step($sformatf("idle%0d", i), idle(i, 0, 1, 0));

    // Table of single-cycle operations and priority combinations.
    do_reset("rst1");
    for (int i = 0; i < 12; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Call at PC 5, three idles, return to 6.
    do_reset("rst2");
    for (int i = 1; i <= 5; i++) step("c34.pre", idle(i, 0, 1, 0));
    step("c34.call", mk(0, 0, 1, 0, 0, 100, 0, 100, 0, 0, 0));
    step("c34.i1", idle(101, 0, 0, 0));
    step("c34.i2", idle(102, 0, 0, 0));
    step("c34.i3", idle(103, 0, 0, 0));
    step("c34.ret", mk(0, 1, 0, 0, 0, 0, 0, 6, 0, 1, 0));

    // Overflow: DEPTH+1 calls, then drain and underflow.
    do_reset("rst3");
    for (int i = 1; i < DEPTH; i++) step($sformatf("c35.call%0d", i), mk(0, 0, 1, 0, 0, 40, 0, 40, 0, 0, 0));
    step("c35.callfull", mk(0, 0, 1, 0, 0, 40, 0, 40, 1, 0, 0));
    step("c35.callovf",  mk(0, 0, 1, 0, 0, 40, 0, 41, 1, 0, 1));
    step("c35.ret1", mk(0, 1, 0, 0, 0, 0, 0, 41, 0, 0, 1));
    step("c35.ret2", mk(0, 1, 0, 0, 0, 0, 0, 41, 0, 0, 1));
    step("c35.ret3", mk(0, 1, 0, 0, 0, 0, 0, 41, 0, 0, 1));
    step("c35.ret4", mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    step("c35.retunf", mk(0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 1));

    // Negative relative jump wrapping below zero.
    do_reset("rst4");
    step("c36.i1", idle(1, 0, 1, 0));
    step("c36.i2", idle(2, 0, 1, 0));
    step("c36.rel", mk(0, 0, 0, 0, 1, 0, 'hFFD, 4095, 0, 1, 0));
    step("c36.wrap", idle(0, 0, 1, 0));

    // Return beats absolute jump; stall holds everything.
    do_reset("rst5");
    step("c37.abs", mk(0, 0, 0, 1, 0, 6, 0, 6, 0, 1, 0));
    step("c37.call", mk(0, 0, 1, 0, 0, 'h80, 0, 'h80, 0, 0, 0));
    step("c37.retabs", mk(0, 1, 0, 1, 0, 'h123, 0, 7, 0, 1, 0));
    for (int i = 0; i < 4; i++) step($sformatf("c37.stall%0d", i), mk(1, 1, 1, 1, 1, 'h123, 5, 7, 0, 1, 0));
    step("c37.resume", idle(8, 0, 1, 0));

    // Underflow, then async reset mid-cycle during a pending call.
    do_reset("rst6");
    step("c38.abs", mk(0, 0, 0, 1, 0, 20, 0, 20, 0, 1, 0));
    step("c38.retunf", mk(0, 1, 0, 0, 0, 0, 0, 21, 0, 1, 1));
    clear_inputs();
    call_en = 1'b1;
    target  = 'h010;
    #2;
    reset = 1'b0;
    #1;
    chk("c38.async.pc",    int'(prog_ctr),    0);
    chk("c38.async.err",   int'(stack_err),   0);
    chk("c38.async.empty", int'(stack_empty), 1);
    @(posedge clk); #1;
    chk("c38.held.pc",  int'(prog_ctr),    0);
    chk("c38.held.empty", int'(stack_empty), 1);
    reset = 1'b1;
    step("c38.postcall", mk(0, 0, 1, 0, 0, 'h010, 0, 'h010, 0, 0, 0));
    step("c38.postret",  mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The module SHALL have parameter D, default 12, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning return-stack entries (power of two, 2..16).
REQ-003 The module SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port stall  input  1  hold all state this cycle.
REQ-006 The module SHALL have port absjump_en  input  1  load target into PC.
REQ-007 The module SHALL have port reljump_en  input  1  add offset to PC.
REQ-008 The module SHALL have port call_en  input  1  push return address, load target.
REQ-009 The module SHALL have port ret_en  input  1  pop return address into PC.
REQ-010 The module SHALL have port target  input  D  absolute destination from the jump LUT.
REQ-011 The module SHALL have port offset  input  D  two's-complement relative displacement.
REQ-012 The module SHALL have port prog_ctr  output  D  current program counter.
REQ-013 The module SHALL have port stack_full  output  1  return stack holds DEPTH entries.
REQ-014 The module SHALL have port stack_empty  output  1  return stack holds zero entries.
REQ-015 The module SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-016 prog_ctr SHALL be registered; every non-stalled operation takes effect on the next rising clk edge (latency 1).
REQ-017 Operation priority SHALL be ret_en > call_en > absjump_en > reljump_en > increment; lower-priority enables are ignored when a higher one is set.
REQ-018 Increment: prog_ctr <= prog_ctr + 1, modulo 2^D (max value wraps to 0).
REQ-019 Relative jump: prog_ctr <= prog_ctr + offset, sign-extended, modulo 2^D.
REQ-020 Absolute jump: prog_ctr <= target.
REQ-021 Call with stack not full: push (prog_ctr + 1) mod 2^D, prog_ctr <= target, occupancy +1.
REQ-022 Call with stack full: no push, prog_ctr <= prog_ctr + 1, stack_err set.
REQ-023 Return with stack not empty: prog_ctr <= top entry, occupancy -1.
REQ-024 Return with stack empty: prog_ctr <= prog_ctr + 1, stack_err set.
REQ-025 stall=1 SHALL override all enables: prog_ctr, stack contents, occupancy and stack_err unchanged.
REQ-026 stack_full and stack_empty SHALL be decoded combinationally from registered occupancy (0..DEPTH).
REQ-027 stack_err SHALL remain set until reset; no other event clears it.

Reset
REQ-028 reset low SHALL immediately force prog_ctr=0, occupancy=0, stack_err=0, independent of clk.
REQ-029 After reset: stack_empty=1, stack_full=0; stack entry contents are don't-care.
REQ-030 Reset asserted mid-call or mid-return SHALL abort the operation; the first edge after deassertion performs a normal operation from PC 0.

Structure
REQ-031 Package pc_seq_pkg SHALL hold the operation enum (OP_NEXT, OP_REL, OP_ABS, OP_CALL, OP_RET) and the default D/DEPTH constants.
REQ-032 The return stack SHALL be a sub-module pc_ret_stack (push, pop, top, full, empty, occupancy); the priority decode and PC register stay in pc_seq.

Verification
REQ-033 Reset then 10 idle cycles -> prog_ctr=10, stack_empty=1, stack_err=0.
REQ-034 At PC=5, call_en with target=100 -> PC=100; then 3 idle cycles, ret_en -> PC=6, stack_empty=1.
REQ-035 DEPTH+1 consecutive calls with target=40 -> first DEPTH push, stack_full=1; last gives PC=41, stack_err=1.
REQ-036 reljump_en with offset=-3 at PC=2 (D=12) -> PC=4095; next idle -> PC=0.
REQ-037 ret_en and absjump_en together with one entry 7 on stack -> PC=7; stall=1 for 4 cycles -> PC stays 7.
REQ-038 ret_en with empty stack at PC=20 -> PC=21, stack_err=1; async reset low mid-cycle -> PC=0 and stack_err=0 before next edge.
